// File: rtl/axi_rd_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// axi_rd_arbiter_pkg
// Shared definitions for the instruction/data cache read arbiter:
//   - rd_type encodings used by both caches
//   - AXI AR burst/size constants
//   - AXI ID values for the two requesters (inst=0, data=1)
//   - FSM state enum
//   - helpers that map a cache rd_type onto the AXI arsize/arlen fields
// ---------------------------------------------------------------------------
package axi_rd_arbiter_pkg;

  // Cache read type encodings
  localparam logic [2:0] RD_TYPE_BYTE = 3'b000;
  localparam logic [2:0] RD_TYPE_HALF = 3'b001;
  localparam logic [2:0] RD_TYPE_WORD = 3'b010;
  localparam logic [2:0] RD_TYPE_LINE = 3'b100;

  // AXI constants
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [2:0] AXI_SIZE_4B    = 3'b010;

  // AXI IDs of the two requesters
  localparam logic [3:0] INST_ID = 4'd0;
  localparam logic [3:0] DATA_ID = 4'd1;

  // Read FSM: one transfer outstanding at any time
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } rd_state_e;

  // A line fill always moves full 32-bit words; narrower reads use the
  // low two bits of rd_type directly as the AXI size code.
  function automatic logic [2:0] rd_type_to_arsize(input logic [2:0] rd_type);
    logic [2:0] size_v;
    if (rd_type == RD_TYPE_LINE) begin
      size_v = AXI_SIZE_4B;
    end else begin
      size_v = {1'b0, rd_type[1:0]};
    end
    return size_v;
  endfunction

  // Only line fills are bursts; everything else is a single beat.
  function automatic logic [7:0] rd_type_to_arlen(input logic [2:0] rd_type,
                                                  input logic [7:0] line_len);
    logic [7:0] len_v;
    if (rd_type == RD_TYPE_LINE) begin
      len_v = line_len;
    end else begin
      len_v = 8'd0;
    end
    return len_v;
  endfunction

endpackage

// File: rtl/axi_rd_arbiter_arb_rr2.sv
// ---------------------------------------------------------------------------
// arb_rr2
// Two-requester round-robin grant with a single pointer bit. When both
// requesters are eligible the one granted last loses. The pointer only
// moves on an actual acceptance, so a grant that is offered but not taken
// does not rotate priority. Grants are combinational.
// Used by axi_rd_arbiter only when RD_ARB_RR_EN is defined.
//
// Ports:
//   clk, resetn        clock, asynchronous active-low reset
//   req_inst, req_data eligibility of each requester
//   accept             a grant was accepted this cycle
//   gnt_inst, gnt_data one-hot (or zero) grant
// ---------------------------------------------------------------------------
module arb_rr2 (
  input  logic clk,
  input  logic resetn,
  input  logic req_inst,
  input  logic req_data,
  input  logic accept,
  output logic gnt_inst,
  output logic gnt_data
);

  // 1: data wins a tie, 0: inst wins a tie. Resets data-first.
  logic data_first_r;

  // Grant selection: single requester always wins, ties follow the pointer
  always_comb begin
    gnt_inst = 1'b0;
    gnt_data = 1'b0;
    if (req_inst && req_data) begin
      if (data_first_r) begin
        gnt_data = 1'b1;
      end else begin
        gnt_inst = 1'b1;
      end
    end else begin
      gnt_inst = req_inst;
      gnt_data = req_data;
    end
  end

  // Pointer update: the requester just accepted gets lowest priority next
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      data_first_r <= 1'b1;
    end else if (accept) begin
      data_first_r <= gnt_inst;
    end else begin
      data_first_r <= data_first_r;
    end
  end

endmodule

// File: rtl/axi_rd_arbiter.sv
// ---------------------------------------------------------------------------
// axi_rd_arbiter
// Arbitrates instruction-cache and data-cache read requests onto a single
// AXI read channel with exactly one transfer outstanding. The AR payload is
// latched at acceptance and held until arready; R beats are steered back to
// the cache selected by rid[0].
//
// Configuration macro: RD_ARB_RR_EN
//   defined   - two-way round-robin between inst and data (arb_rr2)
//   undefined - fixed priority, data over inst
//
// Ports:
//   clk, resetn                       clock, async active-low reset
//   {inst,data}_rd_req/type/addr      cache read request
//   {inst,data}_rd_rdy                request accepted this cycle
//   {inst,data}_ret_valid/last/data   return beats to each cache
//   wr_buf_empty                      data reads only allowed when set
//   arid..arburst, arvalid, arready   AXI AR channel
//   rid, rdata, rlast, rvalid, rready AXI R channel
// ---------------------------------------------------------------------------
module axi_rd_arbiter
  import axi_rd_arbiter_pkg::*;
#(
  parameter int LINE_WORDS = 8
) (
  input  logic        clk,
  input  logic        resetn,
  // instruction cache
  input  logic        inst_rd_req,
  input  logic [2:0]  inst_rd_type,
  input  logic [31:0] inst_rd_addr,
  output logic        inst_rd_rdy,
  output logic        inst_ret_valid,
  output logic        inst_ret_last,
  output logic [31:0] inst_ret_data,
  // data cache
  input  logic        data_rd_req,
  input  logic [2:0]  data_rd_type,
  input  logic [31:0] data_rd_addr,
  output logic        data_rd_rdy,
  output logic        data_ret_valid,
  output logic        data_ret_last,
  output logic [31:0] data_ret_data,
  input  logic        wr_buf_empty,
  // AXI AR
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic        arvalid,
  input  logic        arready,
  // AXI R
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready
);

  localparam logic [7:0] LINE_LEN = 8'(LINE_WORDS - 1);

  rd_state_e   state_r;
  rd_state_e   next_state_s;

  logic        inst_elig_s;
  logic        data_elig_s;
  logic        gnt_inst_s;
  logic        gnt_data_s;
  logic        accept_s;

  logic [31:0] sel_addr_s;
  logic [2:0]  sel_type_s;
  logic [3:0]  sel_id_s;

  logic [3:0]  arid_r;
  logic [31:0] araddr_r;
  logic [7:0]  arlen_r;
  logic [2:0]  arsize_r;
  logic [1:0]  arburst_r;

  // Only rid[0] distinguishes the two caches
  logic        unused_rid_s;
  assign unused_rid_s = ^rid[3:1];

  // A data read may not overtake a pending write, so it is held off
  // until the write buffer drains.
  assign inst_elig_s = inst_rd_req;
  assign data_elig_s = data_rd_req & wr_buf_empty;

`ifdef RD_ARB_RR_EN
  arb_rr2 u_arb_rr2 (
    .clk      (clk),
    .resetn   (resetn),
    .req_inst (inst_elig_s),
    .req_data (data_elig_s),
    .accept   (accept_s),
    .gnt_inst (gnt_inst_s),
    .gnt_data (gnt_data_s)
  );
`else
  // Fixed priority grant: data always beats inst
  always_comb begin
    gnt_inst_s = 1'b0;
    gnt_data_s = 1'b0;
    if (data_elig_s) begin
      gnt_data_s = 1'b1;
    end else if (inst_elig_s) begin
      gnt_inst_s = 1'b1;
    end else begin
      gnt_inst_s = 1'b0;
      gnt_data_s = 1'b0;
    end
  end
`endif

  // Acceptance is only possible in IDLE and never while reset is asserted
  assign accept_s = resetn & (state_r == ST_IDLE) & (gnt_inst_s | gnt_data_s);

  // Mux the granted requester's fields for latching
  always_comb begin
    sel_addr_s = inst_rd_addr;
    sel_type_s = inst_rd_type;
    sel_id_s   = INST_ID;
    if (gnt_data_s) begin
      sel_addr_s = data_rd_addr;
      sel_type_s = data_rd_type;
      sel_id_s   = DATA_ID;
    end else begin
      sel_addr_s = inst_rd_addr;
      sel_type_s = inst_rd_type;
      sel_id_s   = INST_ID;
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // FSM next-state logic
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          next_state_s = ST_ADDR;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_ADDR: begin
        if (arready) begin
          next_state_s = ST_DATA;
        end else begin
          next_state_s = ST_ADDR;
        end
      end
      ST_DATA: begin
        if (rvalid && rlast) begin
          next_state_s = ST_IDLE;
        end else begin
          next_state_s = ST_DATA;
        end
      end
      default: begin
        next_state_s = ST_IDLE;
      end
    endcase
  end

  // FSM outputs: handshakes and return-beat steering
  always_comb begin
    inst_rd_rdy    = 1'b0;
    data_rd_rdy    = 1'b0;
    arvalid        = 1'b0;
    rready         = 1'b0;
    inst_ret_valid = 1'b0;
    inst_ret_last  = 1'b0;
    data_ret_valid = 1'b0;
    data_ret_last  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        inst_rd_rdy = resetn & gnt_inst_s;
        data_rd_rdy = resetn & gnt_data_s;
      end
      ST_ADDR: begin
        arvalid = 1'b1;
      end
      ST_DATA: begin
        rready = 1'b1;
        if (rvalid) begin
          if (rid[0]) begin
            data_ret_valid = 1'b1;
            data_ret_last  = rlast;
          end else begin
            inst_ret_valid = 1'b1;
            inst_ret_last  = rlast;
          end
        end else begin
          inst_ret_valid = 1'b0;
          data_ret_valid = 1'b0;
        end
      end
      default: begin
        arvalid = 1'b0;
        rready  = 1'b0;
      end
    endcase
  end

  // AR payload: captured on acceptance and held for the whole transfer
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      arid_r    <= 4'd0;
      araddr_r  <= 32'd0;
      arlen_r   <= 8'd0;
      arsize_r  <= 3'd0;
      arburst_r <= 2'd0;
    end else if (accept_s) begin
      arid_r    <= sel_id_s;
      araddr_r  <= sel_addr_s;
      arlen_r   <= rd_type_to_arlen(sel_type_s, LINE_LEN);
      arsize_r  <= rd_type_to_arsize(sel_type_s);
      arburst_r <= AXI_BURST_INCR;
    end else begin
      arid_r    <= arid_r;
      araddr_r  <= araddr_r;
      arlen_r   <= arlen_r;
      arsize_r  <= arsize_r;
      arburst_r <= arburst_r;
    end
  end

  assign arid    = arid_r;
  assign araddr  = araddr_r;
  assign arlen   = arlen_r;
  assign arsize  = arsize_r;
  assign arburst = arburst_r;

  // Return data goes straight through; ret_valid tells each cache when to look
  assign inst_ret_data = rdata;
  assign data_ret_data = rdata;

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Self-checking bench for axi_rd_arbiter: transaction-level reference model,
// AXI slave stimulus, directed scenarios plus a randomized phase.
module tb_axi_rd_arbiter;

  localparam int LW = 8;

  logic        clk = 1'b0;
  logic        resetn;
  logic        inst_rd_req, data_rd_req, wr_buf_empty;
  logic [2:0]  inst_rd_type, data_rd_type;
  logic [31:0] inst_rd_addr, data_rd_addr;
  logic        inst_rd_rdy, data_rd_rdy;
  logic        inst_ret_valid, inst_ret_last, data_ret_valid, data_ret_last;
  logic [31:0] inst_ret_data, data_ret_data;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arvalid, arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic        rlast, rvalid, rready;

  always #5 clk = ~clk;

  axi_rd_arbiter #(.LINE_WORDS(LW)) dut (
    .clk(clk), .resetn(resetn),
    .inst_rd_req(inst_rd_req), .inst_rd_type(inst_rd_type), .inst_rd_addr(inst_rd_addr),
    .inst_rd_rdy(inst_rd_rdy), .inst_ret_valid(inst_ret_valid), .inst_ret_last(inst_ret_last),
    .inst_ret_data(inst_ret_data),
    .data_rd_req(data_rd_req), .data_rd_type(data_rd_type), .data_rd_addr(data_rd_addr),
    .data_rd_rdy(data_rd_rdy), .data_ret_valid(data_ret_valid), .data_ret_last(data_ret_last),
    .data_ret_data(data_ret_data), .wr_buf_empty(wr_buf_empty),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rlast(rlast), .rvalid(rvalid), .rready(rready)
  );

  // ---------------- reference model (transaction level) ----------------
  bit          m_busy, m_ar_pend, m_id, m_last_data;
  logic [31:0] m_addr;
  logic [7:0]  m_len;
  logic [2:0]  m_size;
  logic [1:0]  m_burst;
  int          m_beats, m_ar_wait;
  bit          e_gi, e_gd;

  // stimulus knobs
  int k_ar_delay = 0;
  bit k_ar_rand  = 1'b0;
  int k_r_pct    = 100;
  int k_spur_pct = 0;

  // outputs observed at the last sample point
  logic        o_irdy, o_drdy, o_arvalid, o_rready, o_iv, o_il, o_dv, o_dl;
  logic [3:0]  o_arid;
  logic [31:0] o_araddr;
  logic [7:0]  o_arlen;
  logic [2:0]  o_arsize;
  logic [1:0]  o_arburst;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic model_reset();
    m_busy = 0; m_ar_pend = 0; m_id = 0; m_last_data = 0;
    m_addr = '0; m_len = '0; m_size = '0; m_burst = '0;
    m_beats = 0; m_ar_wait = 0;
  endtask

  // AXI slave behaviour, driven from the model's view of the transfer
  task automatic drive_slave();
    if (!resetn) begin
      arready = 0; rvalid = 0; rlast = 0; rid = '0; rdata = '0;
    end else begin
      arready = 1'($urandom_range(0, 1));
      rdata   = $urandom;
      rvalid  = 0; rlast = 0; rid = '0;
      if (m_busy && m_ar_pend) arready = (m_ar_wait == 0);
      if (m_busy && !m_ar_pend) begin
        rvalid = ($urandom_range(0, 99) < k_r_pct);
        rid    = {3'($urandom_range(0, 7)), m_id};
        rlast  = (m_beats == 1);
      end else begin
        rvalid = ($urandom_range(0, 99) < k_spur_pct);
        rid    = 4'($urandom_range(0, 15));
        rlast  = 1'($urandom_range(0, 1));
      end
    end
  endtask

  task automatic update_model();
    if (!resetn) begin
      model_reset();
    end else if (!m_busy) begin
      if (e_gi || e_gd) begin
        logic [2:0] t;
        t           = e_gd ? data_rd_type : inst_rd_type;
        m_addr      = e_gd ? data_rd_addr : inst_rd_addr;
        m_busy      = 1; m_ar_pend = 1; m_id = e_gd;
        m_len       = (t == 3'b100) ? 8'(LW - 1) : 8'd0;
        m_size      = (t == 3'b100) ? 3'd2 : {1'b0, t[1:0]};
        m_burst     = 2'b01;
        m_beats     = int'(m_len) + 1;
        m_last_data = e_gd;
        m_ar_wait   = k_ar_rand ? int'($urandom_range(0, 3)) : k_ar_delay;
      end
    end else if (m_ar_pend) begin
      if (arready) m_ar_pend = 0;
      else if (m_ar_wait > 0) m_ar_wait--;
    end else if (rvalid) begin
      m_beats--;
      if (rlast) m_busy = 0;
    end
  endtask

  // One clock: drive slave, compare at negedge, advance model at posedge
  task automatic step();
    bit ie, de, r_ok;
    drive_slave();
    @(negedge clk);
    if (!resetn) model_reset();
    e_gi = 0; e_gd = 0;
    if (resetn && !m_busy) begin
      ie = inst_rd_req;
      de = data_rd_req && wr_buf_empty;
      if (ie && de) begin
`ifdef RD_ARB_RR_EN
        if (m_last_data) e_gi = 1; else e_gd = 1;
`else
        e_gd = 1;
`endif
      end else begin
        e_gi = ie; e_gd = de;
      end
    end
    r_ok = resetn && m_busy && !m_ar_pend && rvalid;
    o_irdy = inst_rd_rdy; o_drdy = data_rd_rdy; o_arvalid = arvalid; o_rready = rready;
    o_iv = inst_ret_valid; o_il = inst_ret_last; o_dv = data_ret_valid; o_dl = data_ret_last;
    o_arid = arid; o_araddr = araddr; o_arlen = arlen; o_arsize = arsize; o_arburst = arburst;
    check("handshake", {o_irdy, o_drdy, o_arvalid, o_rready},
          {e_gi, e_gd, m_busy && m_ar_pend, m_busy && !m_ar_pend});
    check("ar_payload", {o_arid, o_araddr, o_arlen, o_arsize, o_arburst},
          {3'b000, m_id, m_addr, m_len, m_size, m_burst});
    check("ret_ctl", {o_iv, o_dv, o_il, o_dl},
          {r_ok && !rid[0], r_ok && rid[0], r_ok && !rid[0] && rlast, r_ok && rid[0] && rlast});
    if (o_iv) check("inst_ret_data", inst_ret_data, rdata);
    if (o_dv) check("data_ret_data", data_ret_data, rdata);
    @(posedge clk);
    update_model();
    #1;
  endtask

  task automatic set_reqs(input bit ir, input logic [2:0] it, input logic [31:0] ia,
                          input bit dr, input logic [2:0] dt, input logic [31:0] da);
    inst_rd_req = ir; inst_rd_type = it; inst_rd_addr = ia;
    data_rd_req = dr; data_rd_type = dt; data_rd_addr = da;
  endtask

  task automatic wait_idle(input string name);
    for (int i = 0; i < 100; i++) begin
      if (!m_busy) break;
      step();
    end
    check(name, m_busy, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int beats, ar_cyc, ngr;
    bit saw_last;
    bit gseq[4];
    bit eseq[4];
    logic [2:0] type_tbl[4];
    type_tbl = '{3'b000, 3'b001, 3'b010, 3'b100};
    model_reset();
    resetn = 0; wr_buf_empty = 1;
    arready = 0; rvalid = 0; rlast = 0; rid = '0; rdata = '0;
    set_reqs(1, 3'b010, 32'h0000_0040, 1, 3'b010, 32'h0000_0080);

    // reset: everything zero even with requests pending
    repeat (3) step();
    check("rst_outputs", {o_irdy, o_drdy, o_arvalid, o_rready, o_iv, o_dv, o_il, o_dl}, 8'h00);
    check("rst_payload", {o_arid, o_araddr, o_arlen, o_arsize, o_arburst}, 49'd0);
    resetn = 1;
    set_reqs(0, 3'b000, 32'h0, 0, 3'b000, 32'h0);
    repeat (2) step();

    // inst line fill, arready after 3 cycles
    k_ar_delay = 3; k_r_pct = 100;
    set_reqs(1, 3'b100, 32'h1C00_0000, 0, 3'b000, 32'h0);
    step();
    check("line_rdy", o_irdy, 1);
    set_reqs(0, 3'b000, 32'h0, 0, 3'b000, 32'h0);
    beats = 0; ar_cyc = 0; saw_last = 0;
    for (int i = 0; i < 40 && !saw_last; i++) begin
      step();
      if (o_arvalid) begin
        ar_cyc++;
        check("line_ar", {o_araddr, o_arlen, o_arsize, o_arid}, {32'h1C00_0000, 8'd7, 3'd2, 4'd0});
      end
      if (o_iv) beats++;
      if (o_il) saw_last = 1;
    end
    check("line_ar_cycles", ar_cyc, 4);
    check("line_beats", beats, 8);
    check("line_last_seen", saw_last, 1);

    // data word read held off by a non-empty write buffer
    k_ar_delay = 1;
    wr_buf_empty = 0;
    set_reqs(0, 3'b000, 32'h0, 1, 3'b010, 32'h8000_1004);
    for (int i = 0; i < 5; i++) begin
      step();
      check("wb_blocked", o_drdy, 0);
    end
    wr_buf_empty = 1;
    step();
    check("wb_rdy", o_drdy, 1);
    set_reqs(0, 3'b000, 32'h0, 0, 3'b000, 32'h0);
    wr_buf_empty = 0;   // falling after grant must not abort the read
    beats = 0;
    for (int i = 0; i < 40 && m_busy; i++) begin
      step();
      if (o_arvalid)
        check("word_ar", {o_araddr, o_arlen, o_arsize, o_arid}, {32'h8000_1004, 8'd0, 3'd2, 4'd1});
      if (o_dv) beats++;
    end
    check("word_beats", beats, 1);
    wr_buf_empty = 1;

    // both requesting every cycle
    k_ar_delay = 0;
    set_reqs(1, 3'b010, 32'h0000_0100, 1, 3'b010, 32'h0000_0200);
    ngr = 0;
    for (int i = 0; i < 200 && ngr < 4; i++) begin
      step();
      if (o_irdy || o_drdy) begin
        gseq[ngr] = o_drdy;
        ngr++;
      end
    end
`ifdef RD_ARB_RR_EN
    eseq = '{1'b0, 1'b1, 1'b0, 1'b1};
`else
    eseq = '{1'b1, 1'b1, 1'b1, 1'b1};
`endif
    check("arb_grants", ngr, 4);
    for (int i = 0; i < 4; i++) check("arb_seq", gseq[i], eseq[i]);
    set_reqs(0, 3'b000, 32'h0, 0, 3'b000, 32'h0);
    wait_idle("arb_drain");

    // byte read, request kept high: regrant one cycle after the last beat
    set_reqs(1, 3'b000, 32'h0000_0013, 0, 3'b000, 32'h0);
    saw_last = 0;
    for (int i = 0; i < 20 && !saw_last; i++) begin
      step();
      if (o_arvalid) check("byte_ar", {o_arlen, o_arsize}, {8'd0, 3'd0});
      if (o_iv) begin
        saw_last = 1;
        check("byte_last", o_il, 1);
      end
    end
    check("byte_seen", saw_last, 1);
    step();
    check("byte_regrant", o_irdy, 1);
    set_reqs(0, 3'b000, 32'h0, 0, 3'b000, 32'h0);
    wait_idle("byte_drain");

    // reset in the middle of a line fill, then spurious rvalid in IDLE
    set_reqs(1, 3'b100, 32'h0000_2000, 0, 3'b000, 32'h0);
    step();
    set_reqs(0, 3'b000, 32'h0, 0, 3'b000, 32'h0);
    beats = 0;
    for (int i = 0; i < 20 && beats < 3; i++) begin
      step();
      if (o_iv) beats++;
    end
    check("mid_beats", beats, 3);
    resetn = 0;
    step();
    check("mid_rst_out", {o_irdy, o_drdy, o_arvalid, o_rready, o_iv, o_dv, o_il, o_dl}, 8'h00);
    check("mid_rst_payload", {o_arid, o_araddr, o_arlen, o_arsize, o_arburst}, 49'd0);
    resetn = 1;
    k_spur_pct = 100;
    for (int i = 0; i < 10; i++) begin
      step();
      check("spurious_quiet", {o_iv, o_dv, o_rready}, 3'b000);
    end

    // randomized phase
    k_ar_rand = 1; k_r_pct = 60; k_spur_pct = 20;
    for (int i = 0; i < 1500; i++) begin
      set_reqs(1'($urandom_range(0, 1)), type_tbl[$urandom_range(0, 3)], $urandom,
               1'($urandom_range(0, 1)), type_tbl[$urandom_range(0, 3)], $urandom);
      wr_buf_empty = ($urandom_range(0, 3) != 0);
      resetn = ($urandom_range(0, 299) != 0);
      step();
    end
    resetn = 1;
    set_reqs(0, 3'b000, 32'h0, 0, 3'b000, 32'h0);
    k_r_pct = 100;
    wait_idle("final_drain");

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
